// File: rtl/sobel_window_ctrl.sv
// 3x3 window controller for a raster-order Sobel datapath: two line buffers plus a column shift register.
// Optional macro SOBEL_CTRL_FRAME_CNT_EN adds a 16-bit completed-frame counter output (frame_cnt).
module sobel_window_ctrl #(
    parameter int IMG_W = 64,
    parameter int IMG_H = 64
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [7:0]  pix_in,
    input  logic        pix_valid,
    output logic        pix_ready,
    output logic [71:0] win_data,
    output logic        win_valid,
    input  logic        win_ready,
    output logic        busy,
    output logic        frame_done
`ifdef SOBEL_CTRL_FRAME_CNT_EN
    ,
    output logic [15:0] frame_cnt
`endif
);

    localparam int CW = $clog2(IMG_W);
    localparam int RW = $clog2(IMG_H);
    localparam logic [CW-1:0] COL_LAST  = CW'(IMG_W - 1);
    localparam logic [RW-1:0] ROW_LAST  = RW'(IMG_H - 1);
    localparam logic [CW-1:0] COL_FIRST = CW'(2);
    localparam logic [RW-1:0] ROW_FIRST = RW'(2);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } state_t;

    state_t          state_reg;
    state_t          state_next;
    logic [CW-1:0]   col_cnt_reg;
    logic [RW-1:0]   row_cnt_reg;
    logic            win_valid_reg;
    logic            accept;
    logic            last_pix;
    logic            win_load;

    logic [7:0]      lb1_mem [IMG_W];
    logic [7:0]      lb2_mem [IMG_W];
    logic [7:0]      lb1_rd;
    logic [7:0]      lb2_rd;
    logic [23:0]     col_pack;

    assign accept    = pix_valid & pix_ready;
    assign last_pix  = accept & (col_cnt_reg == COL_LAST) & (row_cnt_reg == ROW_LAST);
    // Only interior pixels complete a window; the first two columns of each row just prime the taps.
    assign win_load  = accept & (row_cnt_reg >= ROW_FIRST) & (col_cnt_reg >= COL_FIRST);
    assign win_valid = win_valid_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (start) state_next = RUN;
            RUN:     if (last_pix) state_next = DRAIN;
            DRAIN:   if (win_valid_reg & win_ready) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        pix_ready  = 1'b0;
        busy       = 1'b0;
        frame_done = 1'b0;
        case (state_reg)
            RUN: begin
                pix_ready = ~win_valid_reg | win_ready;
                busy      = 1'b1;
            end
            DRAIN: begin
                busy       = 1'b1;
                frame_done = win_valid_reg & win_ready;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            col_cnt_reg <= '0;
            row_cnt_reg <= '0;
        end else if ((state_reg == IDLE) && start) begin
            col_cnt_reg <= '0;
            row_cnt_reg <= '0;
        end else if (accept) begin
            if (col_cnt_reg == COL_LAST) begin
                col_cnt_reg <= '0;
                row_cnt_reg <= (row_cnt_reg == ROW_LAST) ? '0 : row_cnt_reg + 1'b1;
            end else begin
                col_cnt_reg <= col_cnt_reg + 1'b1;
            end
        end
    end

    // Line buffers hold rows r-1 (lb1) and r-2 (lb2); contents survive reset on purpose.
    always_ff @(posedge clk) begin
        if (accept) begin
            lb2_mem[col_cnt_reg] <= lb1_mem[col_cnt_reg];
            lb1_mem[col_cnt_reg] <= pix_in;
        end
    end

    assign lb1_rd   = lb1_mem[col_cnt_reg];
    assign lb2_rd   = lb2_mem[col_cnt_reg];
    assign col_pack = {pix_in, lb1_rd, lb2_rd};

    // Each window row is a 3-byte shift register; the newest column enters at byte j=2.
    for (genvar gi = 0; gi < 3; gi++) begin : g_row
        logic [23:0] taps_reg;

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                taps_reg <= '0;
            end else if (accept) begin
                taps_reg <= {col_pack[8*gi +: 8], taps_reg[23:8]};
            end
        end

        assign win_data[24*gi +: 24] = taps_reg;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            win_valid_reg <= 1'b0;
        end else if (win_load) begin
            win_valid_reg <= 1'b1;
        end else if (win_ready) begin
            win_valid_reg <= 1'b0;
        end
    end

`ifdef SOBEL_CTRL_FRAME_CNT_EN
    logic [15:0] frame_cnt_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            frame_cnt_reg <= '0;
        end else if (frame_done) begin
            frame_cnt_reg <= frame_cnt_reg + 16'd1;
        end
    end

    assign frame_cnt = frame_cnt_reg;
`endif

endmodule
